// File: rtl/seq_tx_0110_if.sv
// seq_tx_0110_if: word handshake in, serial frame out, plus status flags.
interface seq_tx_0110_if #(parameter int DATA_W = 16);
  logic bit_en;
  logic [DATA_W-1:0] din;
  logic din_valid;
  logic din_ready;
  logic out;
  logic out_valid;
  logic frame_start;
  logic done;
  logic busy;
  modport master (
    output bit_en, din, din_valid,
    input  din_ready, out, out_valid, frame_start, done, busy
  );
  modport slave (
    input  bit_en, din, din_valid,
    output din_ready, out, out_valid, frame_start, done, busy
  );
endinterface

// File: rtl/seq_tx_0110.sv
// seq_tx_0110: serialises buffered words, each prefixed by a 4-bit sync header.
module seq_tx_0110 #(
  parameter int         DATA_W   = 16,
  parameter logic [3:0] SYNC     = 4'b0110,
  parameter logic       IDLE_BIT = 1'b0
) (
  input logic          clk,
  input logic          rst,
  seq_tx_0110_if.slave bus
);
  localparam int CW = $clog2(DATA_W > 4 ? DATA_W : 4);
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg, hold;
  logic              hold_full, accept, load, last;
  assign accept        = bus.din_valid && !hold_full;
  assign load          = bus.bit_en && state == S_IDLE && hold_full;
  assign last          = state == S_DATA && cnt == CW'(DATA_W - 1);
  assign bus.din_ready = !hold_full;
  assign bus.busy      = state != S_IDLE || hold_full;
  // After the last data bit the FSM passes through IDLE; a full buffer there
  // emits SYNC[3] on that same enabled edge, so back-to-back frames have no gap.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      shreg           <= '0;
      hold            <= '0;
      hold_full       <= 1'b0;
      bus.out         <= IDLE_BIT;
      bus.out_valid   <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      if (accept) hold <= bus.din;
      hold_full       <= accept || (hold_full && !load);
      bus.frame_start <= load;
      bus.done        <= bus.bit_en && last;
      if (bus.bit_en)
        case (state)
          S_IDLE: begin
            bus.out       <= hold_full ? SYNC[3] : IDLE_BIT;
            bus.out_valid <= hold_full;
            if (hold_full) begin
              shreg <= hold;
              cnt   <= CW'(2);
              state <= S_SYNC;
            end
          end
          S_SYNC: begin
            bus.out <= SYNC[cnt[1:0]];
            cnt     <= cnt == '0 ? '0 : cnt - CW'(1);
            if (cnt == '0) state <= S_DATA;
          end
          S_DATA: begin
            bus.out <= shreg[0];
            shreg   <= shreg >> 1;
            cnt     <= last ? '0 : cnt + CW'(1);
            if (last) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_tx_0110.sv
// tb_seq_tx_0110: table-driven frames plus hand sequences, checked via a bit scoreboard.
module tb_seq_tx_0110;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  seq_tx_0110_if #(.DATA_W(16)) bus();
  seq_tx_0110 #(.DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct { logic b; logic fs; logic dn; } exp_t;
  typedef struct { logic [15:0] din; int mode; logic [19:0] exp; } vec_t;
  exp_t q[$];
  vec_t tbl[3];
  int total = 0, bad = 0;
  int en_mode = 0, det_n = 0, cyc = 0, first_fs = -1, last_dn = -1;
  logic last_en, prev_out, prev_valid;
  logic [3:0] det = 4'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
    end
  endtask
  task automatic push(input logic [19:0] e);
    for (int i = 19; i >= 0; i--) q.push_back('{e[i], i == 19, i == 0});
  endtask
  task automatic send(input logic [15:0] d);
    int n = 0;
    logic ok;
    bus.din = d;
    bus.din_valid = 1;
    do begin
      ok = bus.din_ready;
      @(posedge clk); #2;
      n++;
    end while (!ok && n < 100);
    bus.din_valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask
  task automatic drain_idle();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    repeat (3) @(negedge clk);
    chk("idle_valid", bus.out_valid, 0);
    chk("idle_out", bus.out, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_ready", bus.din_ready, 1);
  endtask
  always @(posedge clk or posedge rst) last_en <= rst ? 1'b0 : bus.bit_en;
  initial forever begin
    @(posedge clk); #2;
    bus.bit_en = en_mode == 0 ? 1'b1 : en_mode == 1 ? ~bus.bit_en : 1'b0;
  end
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (last_en && bus.out_valid) begin
        if (q.size() == 0) chk("extra_bit", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("bit", bus.out, e.b);
          chk("frame_start", bus.frame_start, e.fs);
          chk("done", bus.done, e.dn);
          if (e.fs && first_fs < 0) first_fs = cyc;
          if (e.dn) last_dn = cyc;
        end
        det = {det[2:0], bus.out};
        if (det == 4'b0110) det_n++;
      end else begin
        chk("fs_quiet", bus.frame_start, 0);
        chk("done_quiet", bus.done, 0);
        if (bus.out_valid && prev_valid) chk("hold_out", bus.out, prev_out);
      end
      prev_out = bus.out;
      prev_valid = bus.out_valid;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{16'hB5A3, 0, 20'b0110_1100_0101_1010_1101};
    tbl[1] = '{16'h00F0, 1, 20'b0110_0000_1111_0000_0000};
    tbl[2] = '{16'h8000, 0, 20'b0110_0000_0000_0000_0001};
    bus.bit_en = 1;
    bus.din = '0;
    bus.din_valid = 0;
    #1;
    chk("rst_out", bus.out, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_fs", bus.frame_start, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.din_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    repeat (10) begin
      @(negedge clk);
      chk("idle10", {bus.out, bus.out_valid, bus.din_ready, bus.busy}, 4'b0010);
    end
    for (int i = 0; i < 3; i++) begin
      en_mode = tbl[i].mode;
      push(tbl[i].exp);
      send(tbl[i].din);
      chk("ready_drop", bus.din_ready, 0);
      chk("busy_set", bus.busy, 1);
      if (tbl[i].mode == 0) begin
        @(negedge clk); @(negedge clk);
        chk("lat_fs", bus.frame_start, 1);
        chk("lat_valid", bus.out_valid, 1);
        chk("lat_ready", bus.din_ready, 1);
      end
      drain_idle();
    end
    en_mode = 0;
    det = 4'b0;
    det_n = 0;
    first_fs = -1;
    push(20'b0110_1000_0000_0000_0000);
    send(16'h0001);
    push(20'b0110_1111_1111_1111_1111);
    send(16'hFFFF);
    drain_idle();
    chk("b2b_span", last_dn - first_fs, 39);
    chk("b2b_headers", det_n, 2);
    push(20'b0110_0010_1100_0100_1000);
    send(16'h1234);
    repeat (19) @(posedge clk);
    #2;
    chk("lb_ready", bus.din_ready, 1);
    push(20'b0110_0000_0000_0000_0001);
    bus.din = 16'h8000;
    bus.din_valid = 1;
    @(posedge clk); #2;
    bus.din_valid = 0;
    chk("lb_ready_drop", bus.din_ready, 0);
    @(negedge clk);
    chk("lb_done", bus.done, 1);
    @(negedge clk);
    chk("lb_fs", bus.frame_start, 1);
    chk("lb_nogap", bus.out_valid, 1);
    drain_idle();
    push(20'b0110_0010_1100_0100_1000);
    send(16'h1234);
    repeat (8) @(posedge clk);
    #2;
    push(20'b0110_1111_1111_1111_1111);
    send(16'hFFFF);
    chk("rst_buffered", bus.din_ready, 0);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("mid_out", bus.out, 0);
    chk("mid_valid", bus.out_valid, 0);
    chk("mid_fs", bus.frame_start, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_ready", bus.din_ready, 1);
    q.delete();
    @(posedge clk); #2;
    rst = 0;
    push(20'b0110_1010_0101_1010_0101);
    send(16'hA5A5);
    drain_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_tx_0110.md
# seq_tx_0110

Serial frame transmitter for the `0110` sequence-detector path: accepts parallel data words over a valid/ready handshake and emits them one bit per enabled clock on a single serial line. Each word is preceded by the 4-bit sync header `0110`, so the downstream detector sees one header per frame. A one-word holding buffer allows back-to-back frames with no idle bits between them.

## Interface
- `DATA_W`, 16, payload bits per frame (≥2)
- `SYNC`, 4'b0110, sync header value, sent MSB first
- `IDLE_BIT`, 1'b0, line value when no frame is active

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset; one clock, no other clock domains
- `bit_en`  in  1  bit-rate enable; the serial state advances only on cycles where it is 1
- `din`  in  DATA_W  payload word; bit 0 is sent first
- `din_valid`  in  1  `din` is valid
- `din_ready`  out  1  holding buffer is empty; the word is accepted when `din_valid && din_ready` at a rising edge
- `out`  out  1  registered serial output
- `out_valid`  out  1  registered; 1 while `out` carries a sync or data bit
- `frame_start`  out  1  registered; 1 during the cycle `out` carries the first sync bit
- `done`  out  1  registered; 1 during the cycle `out` carries the last data bit
- `busy`  out  1  state ≠ IDLE or buffer full

## Operation
- State machine: IDLE, SYNC (4 bits, counter 3→0), DATA (DATA_W bits, counter 0→DATA_W-1).
- Holding buffer `buf`/`buf_full`. An accepted word sets `buf_full`, regardless of `bit_en`. `din_ready = !buf_full` (combinational from a register).
- IDLE with `buf_full` and `bit_en` moves the buffer into the shift register and clears `buf_full`. The next state is SYNC, and `out` = SYNC[3].
- SYNC: on each `bit_en`, `out` = SYNC[cnt]. After SYNC[0] the next state is DATA.
- DATA: on each `bit_en`, `out` = shreg[0], and the shift register shifts right.
- On the last data bit:
  - If `buf_full` is set, or a word is accepted in the same cycle, the next enabled cycle is SYNC with that word. There is no gap.
  - Otherwise the next state is IDLE.
- Accept and transfer in the same cycle: the buffer stays consistent. When `buf_full` clears and a new word is accepted at the same edge, the buffer holds the new word.
- `bit_en = 0`: `out`, `out_valid`, state and counters hold their values. `frame_start` and `done` are forced to 0.
- In IDLE, `out = IDLE_BIT` and `out_valid = 0`.
- Reset mid-frame: the frame is abandoned and the buffered word is discarded. The line returns to idle immediately. No partial frame resumes after reset.

## Timing
- Reset values:
  - `out = IDLE_BIT`, `out_valid = 0`, `frame_start = 0`, `done = 0`, `busy = 0`
  - `din_ready = 1`, state IDLE, `buf_full = 0`
- Latency with `bit_en` held at 1: a word accepted at edge t from IDLE with an empty buffer sets `buf_full` at t. At t+1 the first sync bit appears (`frame_start = 1`). Data bit 0 appears at t+5. The last data bit appears at t+4+DATA_W (`done = 1`).
- Frame length is 4+DATA_W enabled cycles. Steady-state throughput is one word per 4+DATA_W enabled cycles.
- `din_ready` drops the cycle after acceptance. It rises again the cycle after the buffer transfers into the shift register.
- Output timing is counted in enabled cycles only. Handshake timing is counted in raw clocks.

## Test plan
- Reset, then idle for 10 cycles → `out = 0`, `out_valid = 0`, `din_ready = 1`, `busy = 0` throughout.
- Single word `din = 16'hB5A3`, `bit_en = 1` → `out` = 0,1,1,0, then 1,1,0,0,0,1,0,1,1,0,1,0,1,1,0,1. `frame_start` is high on cycle 1 and `done` on cycle 20. The line is idle from cycle 21.
- Two words offered back-to-back (`16'h0001`, `16'hFFFF`) → the second is accepted during frame 1. Frames are contiguous (40 valid bits, no gap). The detector reference flags exactly two headers.
- `bit_en` toggled 1,0,1,0… with `16'h00F0` → each bit is held for 2 clocks and the serial sequence matches the continuous case. `frame_start` and `done` are 1 for one clock only.
- `rst` pulsed mid-DATA with a word buffered → all outputs are at reset values within the same cycle. The buffer is empty and `din_ready = 1`. A subsequent word transmits as a fresh frame.
- Word accepted in the exact cycle of the last data bit with an empty buffer → SYNC starts on the next enabled cycle with no idle bit.
